// File: rtl/fifo_ctrl_if.sv
// rtl/fifo_ctrl_if.sv - address/strobe/status bundle between the FIFO controller and its user
interface fifo_ctrl_if #(
    parameter int ADDR_W = 3
);
    logic              wr_en;
    logic              rd_en;
    logic              we;
    logic [ADDR_W-1:0] wAddr;
    logic [ADDR_W-1:0] rAddr;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   data_count;
    logic              wr_err;
    logic              rd_err;

    modport master (
        output wr_en, rd_en,
        input  we, wAddr, rAddr, full, empty, data_count, wr_err, rd_err
    );

    modport slave (
        input  wr_en, rd_en,
        output we, wAddr, rAddr, full, empty, data_count, wr_err, rd_err
    );
endinterface

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - head/tail pointer and flag controller for a FWFT FIFO (option: FIFO_ERR_STICKY_EN)
module fifo_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic        clk,
    input  logic        reset,
    fifo_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_NORMAL = 2'd1,
        ST_FULL   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);

    state_t            state, state_d;
    logic [ADDR_W-1:0] head, head_d;
    logic [ADDR_W-1:0] tail, tail_d;
    logic [ADDR_W:0]   count, count_d;
    logic              wr_err, wr_err_d, wr_err_set;
    logic              rd_err, rd_err_d, rd_err_set;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_EMPTY;
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            wr_err <= 1'b0;
            rd_err <= 1'b0;
        end else begin
            state  <= state_d;
            head   <= head_d;
            tail   <= tail_d;
            count  <= count_d;
            wr_err <= wr_err_d;
            rd_err <= rd_err_d;
        end
    end

    always_comb begin
        state_d    = state;
        head_d     = head;
        tail_d     = tail;
        count_d    = count;
        wr_err_set = 1'b0;
        rd_err_set = 1'b0;
        case (state)
            ST_EMPTY: begin
                rd_err_set = bus.rd_en;
                if (bus.wr_en) begin
                    tail_d  = tail + PTR_ONE;
                    count_d = CNT_ONE;
                    state_d = ST_NORMAL;
                end
            end
            ST_NORMAL: begin
                case ({bus.wr_en, bus.rd_en})
                    2'b10: begin
                        tail_d  = tail + PTR_ONE;
                        count_d = count + CNT_ONE;
                        if (count == CNT_LAST) state_d = ST_FULL;
                    end
                    2'b01: begin
                        head_d  = head + PTR_ONE;
                        count_d = count - CNT_ONE;
                        if (count == CNT_ONE) state_d = ST_EMPTY;
                    end
                    2'b11: begin
                        head_d = head + PTR_ONE;
                        tail_d = tail + PTR_ONE;
                    end
                    default: ;
                endcase
            end
            ST_FULL: begin
                // A simultaneous push is still rejected: the slot only frees after this edge.
                wr_err_set = bus.wr_en;
                if (bus.rd_en) begin
                    head_d  = head + PTR_ONE;
                    count_d = CNT_LAST;
                    state_d = ST_NORMAL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
`ifdef FIFO_ERR_STICKY_EN
        wr_err_d = wr_err | wr_err_set;
        rd_err_d = rd_err | rd_err_set;
`else
        wr_err_d = wr_err_set;
        rd_err_d = rd_err_set;
`endif
    end

    assign bus.we         = bus.wr_en & (state != ST_FULL) & ~reset;
    assign bus.wAddr      = tail;
    assign bus.rAddr      = head;
    assign bus.full       = (state == ST_FULL);
    assign bus.empty      = (state == ST_EMPTY);
    assign bus.data_count = count;
    assign bus.wr_err     = wr_err;
    assign bus.rd_err     = rd_err;
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - directed plus random bench for fifo_ctrl against an occupancy model
module tb_fifo_ctrl;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    int m_count, m_head, m_tail;
    bit m_wr_err, m_rd_err;

    fifo_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    fifo_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".count"}, 32'(bus.data_count), 32'(m_count));
        check({tag, ".full"},  32'(bus.full),       32'(m_count == DEPTH));
        check({tag, ".empty"}, 32'(bus.empty),      32'(m_count == 0));
        check({tag, ".wAddr"}, 32'(bus.wAddr),      32'(m_tail));
        check({tag, ".rAddr"}, 32'(bus.rAddr),      32'(m_head));
        check({tag, ".wr_err"}, 32'(bus.wr_err),    32'(m_wr_err));
        check({tag, ".rd_err"}, 32'(bus.rd_err),    32'(m_rd_err));
    endtask

    // One clock with the given requests; called just after a falling edge.
    task automatic cycle(input string tag, input bit w, input bit r);
        bit push_ok, pop_ok;
        reset     = 1'b0;
        bus.wr_en = w;
        bus.rd_en = r;
        #1;
        check_state(tag);
        push_ok = w && (m_count < DEPTH);
        pop_ok  = r && (m_count > 0);
        check({tag, ".we"}, 32'(bus.we), 32'(push_ok));
        @(posedge clk);
        if (push_ok) m_tail = (m_tail + 1) % DEPTH;
        if (pop_ok)  m_head = (m_head + 1) % DEPTH;
        m_count = m_count + int'(push_ok) - int'(pop_ok);
`ifdef FIFO_ERR_STICKY_EN
        m_wr_err = m_wr_err | (w && !push_ok);
        m_rd_err = m_rd_err | (r && !pop_ok);
`else
        m_wr_err = w && !push_ok;
        m_rd_err = r && !pop_ok;
`endif
        @(negedge clk);
    endtask

    task automatic do_reset(input int n, input bit w, input bit r);
        for (int i = 0; i < n; i++) begin
            reset     = 1'b1;
            bus.wr_en = w;
            bus.rd_en = r;
            #1;
            check("reset.we", 32'(bus.we), 32'd0);
            @(posedge clk);
            m_count  = 0;
            m_head   = 0;
            m_tail   = 0;
            m_wr_err = 0;
            m_rd_err = 0;
            @(negedge clk);
        end
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        @(negedge clk);

        do_reset(2, 1'b0, 1'b0);
        #1;
        check_state("reset");
        check("reset.empty_const", 32'(bus.empty), 32'd1);

        for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 1'b0);
        #1;
        check("fill.full_const",  32'(bus.full),       32'd1);
        check("fill.count_const", 32'(bus.data_count), 32'd8);
        cycle("overflow", 1'b1, 1'b0);
        check("overflow.wr_err_const", 32'(bus.wr_err), 32'd1);
        cycle("after_ovf", 1'b0, 1'b0);
        cycle("after_ovf2", 1'b0, 1'b0);

        for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, 1'b1);
        #1;
        check("drain.empty_const", 32'(bus.empty), 32'd1);
        cycle("underflow", 1'b0, 1'b1);
        check("underflow.rd_err_const", 32'(bus.rd_err), 32'd1);
        check("underflow.rAddr_const",  32'(bus.rAddr),  32'd0);
        cycle("after_udf", 1'b0, 1'b0);

        for (int i = 0; i < 3; i++) cycle("pre_both", 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle("both", 1'b1, 1'b1);
        cycle("both_end", 1'b0, 1'b0);

        do_reset(1, 1'b0, 1'b0);
        cycle("both_empty", 1'b1, 1'b1);
        cycle("both_empty_chk", 1'b0, 1'b0);
        for (int i = 0; i < DEPTH - 1; i++) cycle("refill", 1'b1, 1'b0);
        cycle("both_full", 1'b1, 1'b1);
        check("both_full.count_const", 32'(bus.data_count), 32'd7);
        cycle("both_full_chk", 1'b0, 1'b0);

        do_reset(1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b1, 1'b0);
        do_reset(1, 1'b1, 1'b0);
        cycle("mid_rst", 1'b0, 1'b0);

        cycle("sticky_udf", 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) cycle("sticky_hold", i[0], i[1]);
        do_reset(1, 1'b0, 1'b0);
        cycle("sticky_clear", 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) do_reset(1, 1'(($urandom >> 3) & 1), 1'($urandom & 1));
            else cycle("rand", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50));
        end
        #1;
        check_state("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
